uncache_arbiter: RTL and testbench

Shares the single uncached memory port between the write buffer's uncached-store path and the read buffer's uncached-load path. It accepts one request at a time and issues it on the memory port with a byte strobe. For loads it captures the returned word and hands it back to the read buffer. It sits between the write buffer and read buffer on one side and the bus bridge on the other, and is the only master on the uncached memory port.

---
 rtl/uncache_arbiter_pkg.sv | 21 ++
 rtl/uncache_arbiter.sv | 94 +++++++++
 tb/tb_uncache_arbiter.sv | 136 +++++++++++++
 3 files changed

// File: rtl/uncache_arbiter_pkg.sv
// uncache_arbiter_pkg: shared LSU types (Size, arbiter state) and byte-strobe helper
package uncache_arbiter_pkg;
  typedef enum logic [1:0] {
    s_nil  = 2'd0,
    s_byte = 2'd1,
    s_half = 2'd2,
    s_word = 2'd3
  } size_e;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    W_REQ  = 3'd1,
    W_RESP = 3'd2,
    R_REQ  = 3'd3,
    R_RESP = 3'd4,
    R_RET  = 3'd5
  } uarb_state_e;
  function automatic logic [3:0] size_strobe(size_e sz, logic [1:0] a);
    return sz == s_byte ? 4'b0001 << a :
           sz == s_half ? 4'b0011 << {a[1], 1'b0} : 4'b1111;
  endfunction
endpackage

// File: rtl/uncache_arbiter.sv
// uncache_arbiter: shares the uncached memory port between uncached stores and loads
module uncache_arbiter
  import uncache_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        w,
  input  logic [31:0] waddr,
  input  logic [1:0]  size,
  input  logic [31:0] data,
  output logic        ready,
  input  logic        rvalid,
  input  logic [31:0] raddr,
  input  logic [1:0]  rsize,
  input  logic        rready,
  output logic        uready,
  output logic        uvalid,
  output logic [31:0] udata,
  output logic        m_uvalid,
  output logic        m_uwen,
  output logic [31:0] m_uaddr,
  output logic [3:0]  m_ustrobe,
  output logic [31:0] m_uwdata,
  input  logic        mready,
  input  logic        mvalid,
  input  logic [31:0] mdata
);
  uarb_state_e state;
  logic [CNT_W-1:0] cnt;
  logic starve;
  assign starve = cnt >= CNT_W'(STARVE_LIMIT);
  // The m_* registers double as the latched request while it is outstanding.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      ready     <= 1'b0;
      uready    <= 1'b0;
      uvalid    <= 1'b0;
      udata     <= '0;
      m_uvalid  <= 1'b0;
      m_uwen    <= 1'b0;
      m_uaddr   <= '0;
      m_ustrobe <= '0;
      m_uwdata  <= '0;
    end else begin
      ready  <= 1'b0;
      uready <= 1'b0;
      case (state)
        IDLE:
          if (w && !(rvalid && starve)) begin
            state     <= W_REQ;
            ready     <= 1'b1;
            m_uvalid  <= 1'b1;
            m_uwen    <= 1'b1;
            m_uaddr   <= waddr;
            m_ustrobe <= size_strobe(size_e'(size), waddr[1:0]);
            m_uwdata  <= data;
            if (rvalid) cnt <= cnt + 1'b1;
          end else if (rvalid) begin
            state     <= R_REQ;
            uready    <= 1'b1;
            m_uvalid  <= 1'b1;
            m_uwen    <= 1'b0;
            m_uaddr   <= raddr;
            m_ustrobe <= size_strobe(size_e'(rsize), raddr[1:0]);
            m_uwdata  <= '0;
            cnt       <= '0;
          end
        W_REQ, R_REQ:
          if (mready) begin
            m_uvalid <= 1'b0;
            state    <= state == W_REQ ? W_RESP : R_RESP;
          end
        W_RESP: if (mvalid) state <= IDLE;
        R_RESP:
          if (mvalid) begin
            udata  <= mdata;
            uvalid <= 1'b1;
            state  <= R_RET;
          end
        R_RET:
          if (rready) begin
            uvalid <= 1'b0;
            state  <= IDLE;
          end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uncache_arbiter.sv
// tb_uncache_arbiter: randomized requesters and memory against a transaction-phase model
module tb_uncache_arbiter;
  localparam int LIMIT = 4;
  typedef enum {P_IDLE, P_REQ, P_RESP, P_RET} phase_t;
  logic clk = 1'b0, rst;
  logic w, rvalid, rready, mready, mvalid;
  logic [31:0] waddr, data, raddr, mdata;
  logic [1:0] size, rsize;
  logic ready, uready, uvalid, m_uvalid, m_uwen;
  logic [31:0] udata, m_uaddr, m_uwdata;
  logic [3:0] m_ustrobe;
  int checks = 0, errors = 0;
  phase_t ph = P_IDLE;
  bit wr, w_pend, r_pend, did_rst;
  int cnt = 0;
  logic [31:0] w_a, w_d, r_a;
  logic [1:0] w_s, r_s;
  logic e_ready, e_uready, e_mval, e_wen, e_uvalid;
  logic [31:0] e_addr, e_wdata, e_udata;
  logic [3:0] e_strobe;

  always #5 clk = ~clk;

  uncache_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .w(w), .waddr(waddr), .size(size), .data(data), .ready(ready),
    .rvalid(rvalid), .raddr(raddr), .rsize(rsize), .rready(rready), .uready(uready),
    .uvalid(uvalid), .udata(udata), .m_uvalid(m_uvalid), .m_uwen(m_uwen), .m_uaddr(m_uaddr),
    .m_ustrobe(m_ustrobe), .m_uwdata(m_uwdata), .mready(mready), .mvalid(mvalid), .mdata(mdata)
  );

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [3:0] lanes(logic [1:0] sz, logic [31:0] a);
    int off = int'(a % 4);
    return sz == 2'd1 ? 4'(1 << off) : sz == 2'd2 ? 4'(3 << (off / 2 * 2)) : 4'hf;
  endfunction

  // Called just after each rising edge; the request/memory wires still hold what that edge saw.
  task automatic step();
    bit gw, gr;
    if (rst) begin
      ph = P_IDLE; cnt = 0; w_pend = 0; r_pend = 0;
      {e_ready, e_uready, e_mval, e_wen, e_uvalid} = '0;
      check("rst_m_uaddr", m_uaddr, 0);
      check("rst_m_uwdata", m_uwdata, 0);
      check("rst_m_ustrobe", m_ustrobe, 0);
      check("rst_m_uwen", m_uwen, 0);
      check("rst_udata", udata, 0);
    end else begin
      e_ready = 0; e_uready = 0;
      case (ph)
        P_IDLE: begin
          gw = w && (!rvalid || cnt < LIMIT);
          gr = rvalid && !gw;
          if (gw) begin
            if (rvalid) cnt++;
            e_ready = 1; e_mval = 1; e_wen = 1; e_addr = waddr;
            e_strobe = lanes(size, waddr); e_wdata = data;
            ph = P_REQ; wr = 1; w_pend = 0;
          end else if (gr) begin
            cnt = 0;
            e_uready = 1; e_mval = 1; e_wen = 0; e_addr = raddr;
            e_strobe = lanes(rsize, raddr); e_wdata = 0;
            ph = P_REQ; wr = 0; r_pend = 0;
          end
        end
        P_REQ: if (mready) begin e_mval = 0; ph = P_RESP; end
        P_RESP:
          if (mvalid) begin
            if (wr) ph = P_IDLE;
            else begin e_uvalid = 1; e_udata = mdata; ph = P_RET; end
          end
        P_RET: if (rready) begin e_uvalid = 0; ph = P_IDLE; end
      endcase
    end
    check("ready", ready, e_ready);
    check("uready", uready, e_uready);
    check("m_uvalid", m_uvalid, e_mval);
    check("uvalid", uvalid, e_uvalid);
    if (e_mval) begin
      check("m_uwen", m_uwen, e_wen);
      check("m_uaddr", m_uaddr, e_addr);
      check("m_ustrobe", m_ustrobe, e_strobe);
      check("m_uwdata", m_uwdata, e_wdata);
    end
    if (e_uvalid) check("udata", udata, e_udata);
  endtask

  task automatic drive(int cyc);
    int seg = (cyc / 400) % 5;
    int pw = seg == 1 ? 100 : seg == 3 ? 10 : 50;
    int pm = seg == 2 ? 5 : 60;
    int pr = seg == 4 ? 10 : 50;
    if (!did_rst && cyc > 1000 && ph == P_RESP && !wr) begin
      rst = 1; did_rst = 1;
    end else rst = $urandom_range(0, 799) == 0;
    if (!w_pend && $urandom_range(0, 99) < pw) begin
      w_pend = 1; w_a = $urandom; w_s = 2'($urandom_range(0, 3)); w_d = $urandom;
    end
    if (!r_pend && $urandom_range(0, 99) < pw) begin
      r_pend = 1; r_a = $urandom; r_s = 2'($urandom_range(0, 3));
    end
    w = w_pend; rvalid = r_pend;
    waddr = w_pend ? w_a : $urandom; size = w_s; data = w_d;
    raddr = r_pend ? r_a : $urandom; rsize = r_s;
    mready = $urandom_range(0, 99) < pm;
    mvalid = $urandom_range(0, 99) < 40;
    mdata = $urandom;
    rready = $urandom_range(0, 99) < pr;
  endtask

  initial begin
    rst = 1; w = 0; rvalid = 0; rready = 0; mready = 0; mvalid = 0;
    waddr = 0; data = 0; raddr = 0; mdata = 0; size = 0; rsize = 0;
    w_s = 0; r_s = 0; w_d = 0;
    repeat (2) begin @(negedge clk); step(); end
    rst = 0;
    w_pend = 1; w_a = 32'h1FC0_0003; w_s = 2'd1; w_d = 32'hAB00_0000;
    r_pend = 1; r_a = 32'hBFD0_0010; r_s = 2'd3;
    w = 1; waddr = w_a; size = w_s; data = w_d;
    rvalid = 1; raddr = r_a; rsize = r_s;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      step();
      drive(cyc);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
